// File: rtl/nco_sin_monitor_if.sv
// Sample stream from the NCO output stage into the sine monitor.
interface nco_sin_monitor_if #(
  parameter int unsigned mpr = 18
);
  logic [mpr-1:0] fsin_i;
  logic           in_valid;

  modport master (output fsin_i, output in_valid);
  modport slave  (input  fsin_i, input  in_valid);
endinterface

// File: rtl/nco_sin_monitor.sv
// Sine stream checker: hysteretic rising-zero-crossing detector measuring period
// (in accepted samples) and peak-to-peak amplitude per cycle, with timeout.
module nco_sin_monitor #(
  parameter int unsigned mpr  = 18,
  parameter int unsigned cntw = 24,
  parameter int unsigned hyst = 64,
  parameter int unsigned tmo  = 1048575
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clken,
  input  logic                 sclr,
  nco_sin_monitor_if.slave     smp,
  output logic [cntw-1:0]      period_o,
  output logic [mpr:0]         pp_o,
  output logic                 meas_valid_o,
  output logic                 timeout_o,
  output logic                 locked_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARM0 = 2'd1;
  localparam logic [1:0] RUNP = 2'd2;
  localparam logic [1:0] RUNN = 2'd3;

  localparam logic [cntw-1:0]       cnt_sat = '1;
  localparam logic [cntw-1:0]       cnt_tmo = cntw'(tmo);
  localparam logic signed [mpr-1:0] th_pos  = mpr'(hyst);
  localparam logic signed [mpr-1:0] th_neg  = -th_pos;

  logic [1:0]              state, state_nxt;
  logic [cntw-1:0]         cnt, cnt_nxt, cnt_inc;
  logic signed [mpr-1:0]   pk_max, pk_max_nxt, pk_min, pk_min_nxt;
  logic [cntw-1:0]         period_nxt;
  logic [mpr:0]            pp_nxt, pp_calc;
  logic                    meas_nxt, tmo_nxt, locked_nxt;

  logic signed [mpr-1:0]   x, hi, lo;
  logic                    acc, is_neg, is_pos;

  assign x       = smp.fsin_i;
  assign acc     = clken & smp.in_valid;
  assign is_neg  = x < th_neg;
  assign is_pos  = x >= th_pos;
  assign hi      = (x > pk_max) ? x : pk_max;
  assign lo      = (x < pk_min) ? x : pk_min;
  // Sign-extend before subtracting so the full input range cannot overflow.
  assign pp_calc = {hi[mpr-1], hi} - {lo[mpr-1], lo};
  assign cnt_inc = (cnt == cnt_sat) ? cnt : cnt + cntw'(1);

  // Next-state, datapath and pulse generation.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    pk_max_nxt = pk_max;
    pk_min_nxt = pk_min;
    period_nxt = period_o;
    pp_nxt     = pp_o;
    meas_nxt   = 1'b0;
    tmo_nxt    = 1'b0;
    locked_nxt = locked_o;

    if (clken && sclr) begin
      state_nxt  = IDLE;
      cnt_nxt    = '0;
      locked_nxt = 1'b0;
    end else if (acc) begin
      case (state)
        IDLE: begin
          if (is_neg) state_nxt = ARM0;
        end
        ARM0: begin
          if (is_pos) begin
            state_nxt  = RUNP;
            cnt_nxt    = cntw'(1);
            pk_max_nxt = x;
            pk_min_nxt = x;
          end
        end
        default: begin
          pk_max_nxt = hi;
          pk_min_nxt = lo;
          // A crossing on the timeout sample still counts as a measurement.
          if (state == RUNN && is_pos) begin
            state_nxt  = RUNP;
            period_nxt = cnt;
            pp_nxt     = pp_calc;
            cnt_nxt    = cntw'(1);
            pk_max_nxt = x;
            pk_min_nxt = x;
            meas_nxt   = 1'b1;
            locked_nxt = 1'b1;
          end else if (cnt == cnt_tmo) begin
            state_nxt  = IDLE;
            cnt_nxt    = '0;
            tmo_nxt    = 1'b1;
            locked_nxt = 1'b0;
          end else begin
            cnt_nxt = cnt_inc;
            if (state == RUNP && is_neg) state_nxt = RUNN;
          end
        end
      endcase
    end
  end

  // State and output registers; pulses clear every edge regardless of clken.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      pk_max       <= '0;
      pk_min       <= '0;
      period_o     <= '0;
      pp_o         <= '0;
      meas_valid_o <= 1'b0;
      timeout_o    <= 1'b0;
      locked_o     <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      pk_max       <= pk_max_nxt;
      pk_min       <= pk_min_nxt;
      period_o     <= period_nxt;
      pp_o         <= pp_nxt;
      meas_valid_o <= meas_nxt;
      timeout_o    <= tmo_nxt;
      locked_o     <= locked_nxt;
    end
  end

endmodule

// File: tb/tb_nco_sin_monitor.sv
// Directed self-checking bench for nco_sin_monitor (short timeout for run time).
module tb_nco_sin_monitor;
  localparam int unsigned MPR  = 18;
  localparam int unsigned CNTW = 24;
  localparam int unsigned HYST = 64;
  localparam int unsigned TMO  = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic              clken;
  logic              sclr;
  logic [CNTW-1:0]   period_o;
  logic [MPR:0]      pp_o;
  logic              meas_valid_o;
  logic              timeout_o;
  logic              locked_o;

  nco_sin_monitor_if #(.mpr(MPR)) smp ();

  nco_sin_monitor #(.mpr(MPR), .cntw(CNTW), .hyst(HYST), .tmo(TMO)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clken        (clken),
    .sclr         (sclr),
    .smp          (smp),
    .period_o     (period_o),
    .pp_o         (pp_o),
    .meas_valid_o (meas_valid_o),
    .timeout_o    (timeout_o),
    .locked_o     (locked_o)
  );

  int checks   = 0;
  int failures = 0;

  int              meas_cnt, tmo_cnt, wide_cnt, both_cnt;
  logic [CNTW-1:0] per_min, per_max;
  logic [MPR:0]    pp_min, pp_max;
  logic            prev_meas = 1'b0;
  logic            prev_tmo  = 1'b0;

  task automatic clear_stats();
    meas_cnt = 0; tmo_cnt = 0; wide_cnt = 0; both_cnt = 0;
    per_min = '1; per_max = '0; pp_min = '1; pp_max = '0;
  endtask

  // One clock with the given inputs; outputs observed 1 time unit after the edge.
  task automatic step(input int x, input logic v, input logic ce, input logic sc);
    smp.fsin_i   = MPR'(x);
    smp.in_valid = v;
    clken        = ce;
    sclr         = sc;
    @(posedge clk);
    #1;
    if (meas_valid_o) begin
      meas_cnt++;
      if (period_o < per_min) per_min = period_o;
      if (period_o > per_max) per_max = period_o;
      if (pp_o < pp_min) pp_min = pp_o;
      if (pp_o > pp_max) pp_max = pp_o;
    end
    if (timeout_o) tmo_cnt++;
    if (meas_valid_o && timeout_o) both_cnt++;
    if ((meas_valid_o && prev_meas) || (timeout_o && prev_tmo)) wide_cnt++;
    prev_meas = meas_valid_o;
    prev_tmo  = timeout_o;
  endtask

  // n accepted samples of value x; gated mode randomly drops in_valid and clken.
  task automatic feed(input int x, input int n, input bit gated = 1'b0);
    int acc_n = 0;
    int guard = 0;
    logic v, ce;
    if (!gated) begin
      for (int i = 0; i < n; i++) step(x, 1'b1, 1'b1, 1'b0);
    end else begin
      while (acc_n < n && guard < 20 * n) begin
        v  = 1'($urandom_range(0, 1));
        ce = 1'($urandom_range(0, 1));
        step(x, v, ce, 1'b0);
        if (v && ce) acc_n++;
        guard++;
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    smp.fsin_i = '0; smp.in_valid = 1'b0; clken = 1'b1; sclr = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    smp.fsin_i = '0; smp.in_valid = 1'b0; clken = 1'b1; sclr = 1'b0;
    #12;
    checks++; if (period_o !== '0) begin failures++; $display("FAIL rst_period got=%0d exp=0", period_o); end
    checks++; if (pp_o !== '0) begin failures++; $display("FAIL rst_pp got=%0d exp=0", pp_o); end
    checks++; if (meas_valid_o !== 1'b0) begin failures++; $display("FAIL rst_meas got=%0b exp=0", meas_valid_o); end
    checks++; if (timeout_o !== 1'b0) begin failures++; $display("FAIL rst_tmo got=%0b exp=0", timeout_o); end
    checks++; if (locked_o !== 1'b0) begin failures++; $display("FAIL rst_locked got=%0b exp=0", locked_o); end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Square wave +-1000, 50/50: first crossing silent, then period 100, pp 2000.
  task automatic test_square();
    clear_stats();
    feed(-1000, 50);
    for (int k = 0; k < 4; k++) begin
      feed(1000, 50);
      feed(-1000, 50);
    end
    feed(1000, 1);
    checks++; if (meas_cnt !== 4) begin failures++; $display("FAIL sq_meas_cnt got=%0d exp=4", meas_cnt); end
    checks++; if (per_min !== 100 || per_max !== 100) begin failures++; $display("FAIL sq_period got=%0d..%0d exp=100", per_min, per_max); end
    checks++; if (pp_min !== 2000 || pp_max !== 2000) begin failures++; $display("FAIL sq_pp got=%0d..%0d exp=2000", pp_min, pp_max); end
    checks++; if (locked_o !== 1'b1) begin failures++; $display("FAIL sq_locked got=%0b exp=1", locked_o); end
    checks++; if (wide_cnt !== 0 || tmo_cnt !== 0) begin failures++; $display("FAIL sq_pulses wide=%0d tmo=%0d exp=0/0", wide_cnt, tmo_cnt); end
  endtask

  // In-band samples inside a locked cycle are counted but never cross.
  task automatic test_inband();
    clear_stats();
    feed(-1000, 20);
    for (int k = 0; k < 30; k++) begin
      feed(63, 1);
      feed(-63, 1);
    end
    feed(-1000, 20);
    checks++; if (meas_cnt !== 0) begin failures++; $display("FAIL inb_nomeas got=%0d exp=0", meas_cnt); end
    feed(1000, 1);
    checks++; if (meas_cnt !== 1) begin failures++; $display("FAIL inb_meas got=%0d exp=1", meas_cnt); end
    checks++; if (period_o !== 101) begin failures++; $display("FAIL inb_period got=%0d exp=101", period_o); end
    checks++; if (pp_o !== 2000) begin failures++; $display("FAIL inb_pp got=%0d exp=2000", pp_o); end
  endtask

  // Dither +-(hyst-1) from IDLE must not arm the detector.
  task automatic test_dither();
    do_reset();
    clear_stats();
    for (int k = 0; k < 500; k++) begin
      feed(63, 1);
      feed(-63, 1);
    end
    checks++; if (meas_cnt !== 0 || tmo_cnt !== 0) begin failures++; $display("FAIL dith_pulses meas=%0d tmo=%0d exp=0/0", meas_cnt, tmo_cnt); end
    checks++; if (locked_o !== 1'b0) begin failures++; $display("FAIL dith_locked got=%0b exp=0", locked_o); end
    feed(1000, 10);
    feed(-1000, 10);
    feed(1000, 10);
    feed(-1000, 10);
    checks++; if (meas_cnt !== 0) begin failures++; $display("FAIL dith_seq_early got=%0d exp=0", meas_cnt); end
    feed(1000, 1);
    checks++; if (meas_cnt !== 1 || period_o !== 20) begin failures++; $display("FAIL dith_seq_meas cnt=%0d period=%0d exp=1/20", meas_cnt, period_o); end
    checks++; if (pp_o !== 2000) begin failures++; $display("FAIL dith_seq_pp got=%0d exp=2000", pp_o); end
  endtask

  // Held positive level times out on accept TMO after the last crossing.
  task automatic test_timeout();
    clear_stats();
    feed(500, TMO - 1);
    checks++; if (tmo_cnt !== 0 || locked_o !== 1'b1) begin failures++; $display("FAIL tmo_early tmo=%0d locked=%0b exp=0/1", tmo_cnt, locked_o); end
    feed(500, 1);
    checks++; if (timeout_o !== 1'b1) begin failures++; $display("FAIL tmo_pulse got=%0b exp=1", timeout_o); end
    checks++; if (locked_o !== 1'b0) begin failures++; $display("FAIL tmo_locked got=%0b exp=0", locked_o); end
    checks++; if (period_o !== 20 || meas_cnt !== 0) begin failures++; $display("FAIL tmo_hold period=%0d meas=%0d exp=20/0", period_o, meas_cnt); end
    feed(500, 1);
    checks++; if (timeout_o !== 1'b0 || tmo_cnt !== 1) begin failures++; $display("FAIL tmo_width now=%0b cnt=%0d exp=0/1", timeout_o, tmo_cnt); end
    feed(-1000, 10);
    feed(1000, 10);
    feed(-1000, 10);
    checks++; if (meas_cnt !== 0) begin failures++; $display("FAIL tmo_rearm_early got=%0d exp=0", meas_cnt); end
    feed(1000, 1);
    checks++; if (meas_cnt !== 1 || period_o !== 20 || locked_o !== 1'b1) begin failures++; $display("FAIL tmo_resume meas=%0d period=%0d locked=%0b exp=1/20/1", meas_cnt, period_o, locked_o); end
  endtask

  // Crossing on the sample where cnt == TMO wins over the timeout.
  task automatic test_cross_beats_timeout();
    clear_stats();
    feed(-1000, TMO - 1);
    feed(1000, 1);
    checks++; if (meas_cnt !== 1 || tmo_cnt !== 0) begin failures++; $display("FAIL cbt_pulses meas=%0d tmo=%0d exp=1/0", meas_cnt, tmo_cnt); end
    checks++; if (period_o !== TMO) begin failures++; $display("FAIL cbt_period got=%0d exp=%0d", period_o, TMO); end
    checks++; if (locked_o !== 1'b1 || both_cnt !== 0) begin failures++; $display("FAIL cbt_state locked=%0b both=%0d exp=1/0", locked_o, both_cnt); end
  endtask

  // Full-scale swing gives pp = 2^mpr - 1.
  task automatic test_full_range();
    step(0, 1'b1, 1'b1, 1'b1);
    clear_stats();
    feed(-131072, 5);
    feed(131071, 5);
    feed(-131072, 5);
    feed(131071, 1);
    checks++; if (meas_cnt !== 1 || period_o !== 10) begin failures++; $display("FAIL full_period meas=%0d period=%0d exp=1/10", meas_cnt, period_o); end
    checks++; if (pp_o !== 19'h3FFFF) begin failures++; $display("FAIL full_pp got=%0d exp=%0d", pp_o, 262143); end
  endtask

  // Random in_valid/clken gaps: only accepted samples count, pulses stay 1 clk.
  task automatic test_gated();
    step(0, 1'b1, 1'b1, 1'b1);
    clear_stats();
    feed(-1000, 50, 1'b1);
    for (int k = 0; k < 3; k++) begin
      feed(1000, 50, 1'b1);
      feed(-1000, 50, 1'b1);
    end
    feed(1000, 1, 1'b1);
    checks++; if (meas_cnt !== 3) begin failures++; $display("FAIL gate_meas_cnt got=%0d exp=3", meas_cnt); end
    checks++; if (per_min !== 100 || per_max !== 100) begin failures++; $display("FAIL gate_period got=%0d..%0d exp=100", per_min, per_max); end
    checks++; if (pp_min !== 2000 || pp_max !== 2000) begin failures++; $display("FAIL gate_pp got=%0d..%0d exp=2000", pp_min, pp_max); end
    checks++; if (wide_cnt !== 0) begin failures++; $display("FAIL gate_width got=%0d exp=0", wide_cnt); end
  endtask

  // sclr on a crossing suppresses it; async reset mid-cycle clears outputs.
  task automatic test_sclr_reset();
    feed(-1000, 50);
    clear_stats();
    step(1000, 1'b1, 1'b1, 1'b1);
    checks++; if (meas_valid_o !== 1'b0 || locked_o !== 1'b0) begin failures++; $display("FAIL sclr_cross meas=%0b locked=%0b exp=0/0", meas_valid_o, locked_o); end
    checks++; if (period_o !== 100 || pp_o !== 2000) begin failures++; $display("FAIL sclr_hold period=%0d pp=%0d exp=100/2000", period_o, pp_o); end
    feed(1000, 5);
    feed(-1000, 5);
    feed(1000, 5);
    checks++; if (meas_cnt !== 0) begin failures++; $display("FAIL sclr_idle got=%0d exp=0", meas_cnt); end
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (period_o !== '0 || pp_o !== '0) begin failures++; $display("FAIL arst_data period=%0d pp=%0d exp=0/0", period_o, pp_o); end
    checks++; if (meas_valid_o !== 1'b0 || timeout_o !== 1'b0 || locked_o !== 1'b0) begin failures++; $display("FAIL arst_flags got=%0b%0b%0b exp=000", meas_valid_o, timeout_o, locked_o); end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    clear_stats();
    feed(1000, 10);
    feed(-1000, 10);
    feed(1000, 10);
    feed(-1000, 10);
    checks++; if (meas_cnt !== 0) begin failures++; $display("FAIL arst_early got=%0d exp=0", meas_cnt); end
    feed(1000, 1);
    checks++; if (meas_cnt !== 1 || period_o !== 20 || pp_o !== 2000) begin failures++; $display("FAIL arst_first meas=%0d period=%0d pp=%0d exp=1/20/2000", meas_cnt, period_o, pp_o); end
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_square();
    test_inband();
    test_dither();
    test_timeout();
    test_cross_beats_timeout();
    test_full_range();
    test_gated();
    test_sclr_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
